// File: rtl/gpio_mmio_pkg.sv
// Shared constants for the GPIO MMIO block: field widths, register offsets and reset values.
package gpio_mmio_pkg;

  localparam int unsigned GPIO_W = 10;
  localparam int unsigned DBC_W  = 16;

  localparam logic [4:0] OFF_SW     = 5'h00;
  localparam logic [4:0] OFF_LED    = 5'h04;
  localparam logic [4:0] OFF_EDGE   = 5'h08;
  localparam logic [4:0] OFF_TCOUNT = 5'h0C;
  localparam logic [4:0] OFF_TCMP   = 5'h10;
  localparam logic [4:0] OFF_STATUS = 5'h14;

  localparam logic [GPIO_W-1:0] LED_RST    = '0;
  localparam logic [31:0]       TCOUNT_RST = '0;
  localparam logic [31:0]       TCMP_RST   = '1;

  function automatic logic [2:0] reg_idx(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchronizer and shared-counter debouncer; emits a one-cycle rise mask as stable bits go 0->1.
module sw_debounce
  import gpio_mmio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GPIO_W-1:0] switches,
  output logic [GPIO_W-1:0] stable,
  output logic [GPIO_W-1:0] rise,
  output logic              busy
);

  logic [GPIO_W-1:0] sync1, sync2;
  logic [DBC_W-1:0]  cnt;
  logic              load;

  assign load = (sync2 != stable) && (cnt == DBC_W'(DEBOUNCE_CYCLES - 1));
  assign rise = load ? (sync2 & ~stable) : '0;
  assign busy = (cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      // Counter keeps running while sync differs from stable, even if sync itself changes mid-count.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (load) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: debounced switches, LED register, rising-edge flags, free-running timer with compare.
module gpio_mmio
  import gpio_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  input  logic [9:0]  switches,
  output logic [9:0]  leds
);

  logic [GPIO_W-1:0] stable, rise, led_q, edge_q;
  logic [31:0]       tcount, tcmp;
  logic              match, busy, we;
  logic [2:0]        idx;
  logic [GPIO_W-1:0] edge_clr;
  logic              match_clr;
  logic [1:0]        unused_adr;

  assign unused_adr = DataAdr[1:0];
  assign sel        = (DataAdr[31:5] == BASE_ADDR[31:5]);
  assign idx        = DataAdr[4:2];
  assign we         = MemWrite && sel && reset;
  assign leds       = led_q;

  assign edge_clr  = (we && idx == reg_idx(OFF_EDGE)) ? WriteData[GPIO_W-1:0] : '0;
  assign match_clr = we && (idx == reg_idx(OFF_STATUS)) && WriteData[0];

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbc (
    .clk     (clk),
    .reset   (reset),
    .switches(switches),
    .stable  (stable),
    .rise    (rise),
    .busy    (busy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q  <= LED_RST;
      edge_q <= '0;
      tcount <= TCOUNT_RST;
      tcmp   <= TCMP_RST;
      match  <= 1'b0;
    end else begin
      if (we && idx == reg_idx(OFF_LED)) led_q <= WriteData[GPIO_W-1:0];
      if (we && idx == reg_idx(OFF_TCMP)) tcmp <= WriteData;
      if (we && idx == reg_idx(OFF_TCOUNT)) tcount <= WriteData;
      else                                  tcount <= tcount + 32'd1;
      // Set wins over a simultaneous write-1-to-clear.
      edge_q <= rise | (edge_q & ~edge_clr);
      match  <= (tcount == tcmp) | (match & ~match_clr);
    end
  end

  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (idx)
        reg_idx(OFF_SW):     ReadData = {22'd0, stable};
        reg_idx(OFF_LED):    ReadData = {22'd0, led_q};
        reg_idx(OFF_EDGE):   ReadData = {22'd0, edge_q};
        reg_idx(OFF_TCOUNT): ReadData = tcount;
        reg_idx(OFF_TCMP):   ReadData = tcmp;
        reg_idx(OFF_STATUS): ReadData = {30'd0, busy, match};
        default:             ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed self-checking bench for gpio_mmio with hand-computed expectations.
module tb_gpio_mmio;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        sel;
  logic [9:0]  switches = '0;
  logic [9:0]  leds;

  int total = 0;
  int bad = 0;

  gpio_mmio #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .sel      (sel),
    .switches (switches),
    .leds     (leds)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] off, input string tag, input logic [31:0] exp);
    MemWrite = 1'b0;
    DataAdr  = BASE + {27'd0, off};
    #1;
    chk(tag, ReadData, exp);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    tick();
    MemWrite  = 1'b0;
  endtask

  initial begin
    // Reset low for two edges
    tick();
    tick();
    chk("rst_leds", {22'd0, leds}, 32'd0);
    reset = 1'b1;
    rd(5'h04, "rst_led", 32'd0);
    rd(5'h08, "rst_edge", 32'd0);
    rd(5'h10, "rst_tcmp", 32'hFFFF_FFFF);
    rd(5'h14, "rst_status", 32'd0);

    // LED store
    wr(BASE + 32'h04, 32'h0000_03A5);
    chk("led_pins", {22'd0, leds}, 32'h0000_03A5);
    rd(5'h04, "led_read", 32'h0000_03A5);
    wr(BASE + 32'h04, 32'hFFFF_F0A5);
    rd(5'h04, "led_mask", 32'h0000_00A5);
    wr(BASE + 32'h04, 32'h0000_03A5);

    // Unused offsets
    wr(BASE + 32'h1C, 32'hDEAD_BEEF);
    rd(5'h1C, "unused_1c", 32'd0);
    rd(5'h18, "unused_18", 32'd0);

    // Steady switch change: accepted exactly 18 edges later
    switches = 10'h001;
    for (int i = 0; i < 17; i++) tick();
    rd(5'h00, "sw_before", 32'd0);
    rd(5'h14, "busy_mid", 32'h0000_0002);
    tick();
    rd(5'h00, "sw_accept", 32'h0000_0001);
    rd(5'h08, "edge_set", 32'h0000_0001);
    rd(5'h14, "busy_done", 32'd0);
    wr(BASE + 32'h08, 32'h0000_0001);
    rd(5'h08, "edge_w1c", 32'd0);

    // Return to 0: falling edge must not set EDGE
    switches = 10'h000;
    for (int i = 0; i < 20; i++) tick();
    rd(5'h00, "sw_fall", 32'd0);
    rd(5'h08, "edge_fall", 32'd0);

    // Short glitch is rejected
    switches = 10'h002;
    for (int i = 0; i < 5; i++) tick();
    switches = 10'h000;
    rd(5'h14, "glitch_busy", 32'h0000_0002);
    for (int i = 0; i < 20; i++) tick();
    rd(5'h00, "glitch_sw", 32'd0);
    rd(5'h08, "glitch_edge", 32'd0);
    rd(5'h14, "glitch_idle", 32'd0);

    // Timer compare
    wr(BASE + 32'h10, 32'd40);
    wr(BASE + 32'h0C, 32'd30);
    rd(5'h0C, "tcount_load", 32'd30);
    for (int i = 0; i < 9; i++) tick();
    rd(5'h0C, "tcount_run", 32'd39);
    tick();
    rd(5'h14, "match_pre", 32'd0);
    tick();
    rd(5'h14, "match_set", 32'h0000_0001);
    wr(BASE + 32'h0C, 32'd38);
    tick();
    tick();
    wr(BASE + 32'h14, 32'h0000_0001);
    rd(5'h14, "match_setwins", 32'h0000_0001);
    wr(BASE + 32'h14, 32'h0000_0001);
    rd(5'h14, "match_clr", 32'd0);

    // Out-of-window store
    MemWrite  = 1'b1;
    DataAdr   = 32'h0000_0000;
    WriteData = 32'hFFFF_FFFF;
    #1;
    chk("miss_sel", {31'd0, sel}, 32'd0);
    chk("miss_rdata", ReadData, 32'd0);
    tick();
    MemWrite = 1'b0;
    chk("miss_leds", {22'd0, leds}, 32'h0000_03A5);
    rd(5'h10, "miss_tcmp", 32'd40);

    // Reset mid-debounce with a write presented
    switches = 10'h004;
    for (int i = 0; i < 8; i++) tick();
    reset     = 1'b0;
    MemWrite  = 1'b1;
    DataAdr   = BASE + 32'h04;
    WriteData = 32'h0000_03FF;
    switches  = 10'h000;
    tick();
    chk("rst2_leds", {22'd0, leds}, 32'd0);
    tick();
    MemWrite = 1'b0;
    reset    = 1'b1;
    rd(5'h04, "rst2_led", 32'd0);
    rd(5'h14, "rst2_status", 32'd0);
    for (int i = 0; i < 20; i++) tick();
    rd(5'h00, "rst2_sw", 32'd0);
    rd(5'h08, "rst2_edge", 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_mmio.md
GPIO_MMIO -- requirements
Module: gpio_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0400, base byte address of the 32-byte register window.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, cycles a changed switch vector must hold stable before acceptance; legal range 2..65535.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset.
REQ-005 Port MemWrite  input  1  CPU store strobe, sampled on rising clk.
REQ-006 Port DataAdr  input  32  CPU byte address.
REQ-007 Port WriteData  input  32  CPU store data.
REQ-008 Port ReadData  output  32  read data for the addressed register; 0 when not selected.
REQ-009 Port sel  output  1  high when DataAdr hits the window; top uses it to mux ReadData against data memory.
REQ-010 Port switches  input  10  asynchronous board switches.
REQ-011 Port leds  output  10  board LEDs, driven from the LED register.

Function
REQ-012 Window hit: DataAdr[31:5] == BASE_ADDR[31:5]; register index = DataAdr[4:2]; DataAdr[1:0] ignored.
REQ-013 Register map (offset): 0x00 SW RO, 0x04 LED RW, 0x08 EDGE W1C, 0x0C TCOUNT RW, 0x10 TCMP RW, 0x14 STATUS W1C; 0x18/0x1C read 0, writes ignored.
REQ-014 Reads are combinational from registered state (zero latency); writes take effect at the rising edge where MemWrite=1 and sel=1.
REQ-015 Unused upper bits of SW, LED, EDGE, STATUS read 0; LED write stores WriteData[9:0] only.
REQ-016 switches pass a 2-flop synchronizer before any other use; sync-to-SW latency is 2 cycles plus debounce.
REQ-017 Debounce: one shared 16-bit counter; if sync vector != stable vector, counter increments; when counter reaches DEBOUNCE_CYCLES-1 stable vector loads sync vector and counter clears; if sync vector == stable vector, counter clears.
REQ-018 A sync vector that changes value again mid-count does not restart the counter unless it equals stable (glitch shorter than DEBOUNCE_CYCLES is rejected only if it returns to stable).
REQ-019 SW register reads the stable vector.
REQ-020 EDGE[i] sets when stable[i] goes 0->1; writing 1 to EDGE[i] clears it; a set and a clear in the same cycle leave the bit set.
REQ-021 TCOUNT increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0; a write loads WriteData instead of incrementing that cycle.
REQ-022 STATUS[0] (match) sets in the cycle after TCOUNT == TCMP; W1C with set-wins priority as REQ-020.
REQ-023 STATUS[1] reads 1 while the debounce counter is nonzero (debounce busy), read-only.

Reset
REQ-024 While reset=0 at a rising edge: LED=0, EDGE=0, STATUS[0]=0, TCOUNT=0, TCMP=32'hFFFF_FFFF, debounce counter=0, synchronizer and stable vector=0.
REQ-025 Reset mid-debounce discards the pending change; leds=0 in the first cycle after reset edge.
REQ-026 Writes presented during reset are ignored.

Structure
REQ-027 Shared package gpio_mmio_pkg holds register offset constants, reset values, and the field widths (10-bit GPIO, 16-bit debounce counter).
REQ-028 One sub-module, sw_debounce (synchronizer + counter + stable vector + rising-edge pulse output); register file and timer stay in gpio_mmio.

Verification
REQ-029 Reset low 2 cycles then high, read 0x04/0x08/0x10 -> 0, 0, 32'hFFFF_FFFF; leds=0.
REQ-030 Store 32'h0000_03A5 to BASE+0x04 -> leds=10'h3A5 next cycle; read 0x04 returns 32'h0000_03A5.
REQ-031 switches 0 -> 10'h001 held steady (DEBOUNCE_CYCLES=16) -> SW reads 1 exactly 2+16 cycles later, EDGE=1; write 1 to 0x08 -> EDGE=0.
REQ-032 switches pulse 10'h002 for 5 cycles then back to 0 -> SW and EDGE stay 0; STATUS[1] returns to 0.
REQ-033 Write TCMP=32'd40, TCOUNT=32'd30 -> STATUS[0] sets 11 cycles after the TCOUNT write; W1C in same cycle as a new match keeps it 1.
REQ-034 Store to DataAdr=32'h0000_0000 with MemWrite=1 -> sel=0, no register changes, ReadData=0.
